// File: rtl/tt_um_koggestone_sub8_seq_if.sv
// Pin bundle of the sequential Kogge-Stone subtractor tile: operand bus, control pins and outputs.
// The master side drives the tile inputs; the slave side is the tile itself.
interface tt_um_koggestone_sub8_seq_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_koggestone_sub8_seq.sv
// Sequential A - B - bin: operands are strobed in over ui_in, and the difference is formed as
// A + ~B + ~bin through a Kogge-Stone prefix network pipelined across two or three clocks.
module tt_um_koggestone_sub8_seq #(
    parameter int WIDTH      = 8,
    parameter int REG_PREFIX = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    tt_um_koggestone_sub8_seq_if.slave     bus
);

    localparam int         LAT  = 2 + REG_PREFIX;
    localparam logic [1:0] LAST = 2'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_A_LOADED = 2'd1,
        ST_BUSY     = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // One Kogge-Stone level: group generate over distance span.
    function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g,
                                              input logic [WIDTH-1:0] p,
                                              input int span);
        logic [WIDTH-1:0] gn;
        gn = g;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= span) gn[i] = g[i] | (p[i] & g[i - span]);
            else           gn[i] = g[i];
        end
        return gn;
    endfunction

    // One Kogge-Stone level: group propagate over distance span.
    function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p, input int span);
        logic [WIDTH-1:0] pn;
        pn = p;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= span) pn[i] = p[i] & p[i - span];
            else           pn[i] = p[i];
        end
        return pn;
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              bin_q, bin_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              lda_prev_q, lda_prev_d, ldb_prev_q, ldb_prev_d;
    logic [WIDTH-1:0]  s0_g_q, s0_g_d, s0_p_q, s0_p_d;
    logic [WIDTH-1:0]  s1_g_q, s1_g_d, s1_gp_q, s1_gp_d, s1_p_q, s1_p_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              borrow_q, borrow_d, zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

    logic              ld_a_s, ld_b_s, clr_s, bin_in_s, cin_s;
    logic              lda_edge_s, ldb_edge_s;
    logic [WIDTH-1:0]  g_in_s, p_in_s, g_fold_s;
    logic [WIDTH-1:0]  l1_g_s, l1_p_s, l2_g_s, l2_p_s;
    logic [WIDTH-1:0]  s1_g_s, s1_gp_s, s1_p_s, l3_g_s, diff_s;
    logic              unused_s;

    assign ld_a_s     = bus.uio_in[0];
    assign ld_b_s     = bus.uio_in[1];
    assign clr_s      = bus.uio_in[2];
    assign bin_in_s   = bus.uio_in[3];
    assign unused_s   = &{1'b0, bus.uio_in[7:4]};
    assign lda_edge_s = ld_a_s & ~lda_prev_q;
    assign ldb_edge_s = ld_b_s & ~ldb_prev_q;

    // S0 operands; the carry-in is folded into bit 0 so it acts as the bit -1 generate.
    assign cin_s    = ~bin_q;
    assign g_in_s   = a_q & ~b_q;
    assign p_in_s   = a_q ^ ~b_q;
    assign g_fold_s = {g_in_s[WIDTH-1:1], g_in_s[0] | (p_in_s[0] & cin_s)};

    assign l1_g_s = ks_g(s0_g_q, s0_p_q, 1);
    assign l1_p_s = ks_p(s0_p_q, 1);
    assign l2_g_s = ks_g(l1_g_s, l1_p_s, 2);
    assign l2_p_s = ks_p(l1_p_s, 2);

    // With REG_PREFIX=0 the S1 register is bypassed and level 3 follows level 2 directly.
    assign s1_g_s  = (REG_PREFIX != 0) ? s1_g_q  : l2_g_s;
    assign s1_gp_s = (REG_PREFIX != 0) ? s1_gp_q : l2_p_s;
    assign s1_p_s  = (REG_PREFIX != 0) ? s1_p_q  : s0_p_q;
    assign l3_g_s  = ks_g(s1_g_s, s1_gp_s, 4);
    assign diff_s  = s1_p_s ^ {l3_g_s[WIDTH-2:0], cin_s};

    // Next-state, operand capture, pipeline advance and result update.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        lda_prev_d = lda_prev_q;
        ldb_prev_d = ldb_prev_q;
        s0_g_d     = s0_g_q;
        s0_p_d     = s0_p_q;
        s1_g_d     = s1_g_q;
        s1_gp_d    = s1_gp_q;
        s1_p_d     = s1_p_q;
        result_d   = result_q;
        borrow_d   = borrow_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        done_d     = done_q;

        if (!bus.ena) begin
            state_d = state_q;
        end else if (clr_s) begin
            lda_prev_d = ld_a_s;
            ldb_prev_d = ld_b_s;
            state_d    = ST_IDLE;
            a_d        = '0;
            b_d        = '0;
            bin_d      = 1'b0;
            cnt_d      = 2'd0;
            s0_g_d     = '0;
            s0_p_d     = '0;
            s1_g_d     = '0;
            s1_gp_d    = '0;
            s1_p_d     = '0;
            result_d   = '0;
            borrow_d   = 1'b0;
            zero_d     = 1'b0;
            ovf_d      = 1'b0;
            done_d     = 1'b0;
        end else begin
            lda_prev_d = ld_a_s;
            ldb_prev_d = ld_b_s;
            s0_g_d     = g_fold_s;
            s0_p_d     = p_in_s;
            s1_g_d     = l2_g_s;
            s1_gp_d    = l2_p_s;
            s1_p_d     = s0_p_q;
            case (state_q)
                ST_IDLE, ST_A_LOADED, ST_DONE: begin
                    if (lda_edge_s) begin
                        a_d     = bus.ui_in;
                        done_d  = 1'b0;
                        state_d = ST_A_LOADED;
                    end else if (ldb_edge_s) begin
                        b_d     = bus.ui_in;
                        bin_d   = bin_in_s;
                        cnt_d   = 2'd0;
                        done_d  = 1'b0;
                        state_d = ST_BUSY;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == LAST) begin
                        result_d = diff_s;
                        borrow_d = ~l3_g_s[WIDTH-1];
                        zero_d   = (diff_s == '0);
                        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_s[WIDTH-1] != a_q[WIDTH-1]);
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, operand, pipeline and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            bin_q      <= 1'b0;
            cnt_q      <= 2'd0;
            lda_prev_q <= 1'b0;
            ldb_prev_q <= 1'b0;
            s0_g_q     <= '0;
            s0_p_q     <= '0;
            s1_g_q     <= '0;
            s1_gp_q    <= '0;
            s1_p_q     <= '0;
            result_q   <= '0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            lda_prev_q <= lda_prev_d;
            ldb_prev_q <= ldb_prev_d;
            s0_g_q     <= s0_g_d;
            s0_p_q     <= s0_p_d;
            s1_g_q     <= s1_g_d;
            s1_gp_q    <= s1_gp_d;
            s1_p_q     <= s1_p_d;
            result_q   <= result_d;
            borrow_q   <= borrow_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign bus.uo_out  = result_q;
    assign bus.uio_out = {done_q, ovf_q, zero_q, borrow_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;

endmodule
